// File: rtl/clk_gate_ctrl_if.sv
// clk_gate_ctrl_if: requester/control bundle between the clock-gating controller and its clients
interface clk_gate_ctrl_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic               force_on;
    logic [NUM_REQ-1:0] ack;
    logic               gate_en;
    logic               busy;
    logic [15:0]        wake_cnt;

    modport master (
        output req, force_on,
        input  ack, gate_en, busy, wake_cnt
    );

    modport slave (
        input  req, force_on,
        output ack, gate_en, busy, wake_cnt
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: drives a clock AND-gate enable with wake-up delay and idle hysteresis
module clk_gate_ctrl #(
    parameter int NUM_REQ  = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_gate_ctrl_if.slave bus
);
    localparam int MAX_CYC = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {OFF, WAKE, ON, IDLE} state_t;

    state_t             state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [NUM_REQ-1:0] ack_d, ack_q;
    logic               gate_en_pre_d, gate_en_pre_q;
    logic               gate_en_d, gate_en_q;
    logic [15:0]        wake_cnt_d, wake_cnt_q;
    logic               demand;

    assign demand       = (|bus.req) | bus.force_on;
    assign bus.ack      = ack_q;
    assign bus.gate_en  = gate_en_q;
    assign bus.busy     = (state_q != OFF);
    assign bus.wake_cnt = wake_cnt_q;

    // Next-state, counter, grant and pre-enable logic; ack is only ever driven in ON
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        gate_en_pre_d = gate_en_pre_q;
        wake_cnt_d    = wake_cnt_q;
        gate_en_d     = gate_en_pre_q;
        case (state_q)
            OFF: begin
                if (demand) begin
                    state_d       = WAKE;
                    cnt_d         = CNT_W'(WAKE_CYC - 1);
                    gate_en_pre_d = 1'b1;
                    wake_cnt_d    = (wake_cnt_q == 16'hFFFF) ? wake_cnt_q : wake_cnt_q + 16'd1;
                end
            end
            WAKE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ON;
                    ack_d   = bus.req;
                end
            end
            ON: begin
                ack_d = bus.req;
                if (!demand) begin
                    state_d = IDLE;
                    cnt_d   = CNT_W'(IDLE_CYC - 1);
                end
            end
            default: begin
                if (demand) begin
                    state_d = ON;
                    ack_d   = bus.req;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d       = OFF;
                    gate_en_pre_d = 1'b0;
                end
            end
        endcase
    end

    // Posedge state: FSM, counter, grants, pre-enable and wake statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= OFF;
            cnt_q         <= '0;
            ack_q         <= '0;
            gate_en_pre_q <= 1'b0;
            wake_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            gate_en_pre_q <= gate_en_pre_d;
            wake_cnt_q    <= wake_cnt_d;
        end
    end

    // Negedge retiming so the AND-gate enable only moves while clk is low
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_en_q <= 1'b0;
        end else begin
            gate_en_q <= gate_en_d;
        end
    end
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed self-checking bench for clk_gate_ctrl
module tb_clk_gate_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    clk_gate_ctrl_if #(.NUM_REQ(4)) bus ();

    clk_gate_ctrl #(.NUM_REQ(4), .WAKE_CYC(2), .IDLE_CYC(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    // gate_en may only move while clk is low (outside reset)
    always @(bus.gate_en) if (rst_n) chk("gate_en_clk_low", {31'b0, clk}, 32'd0);

    // any grant implies the gated clock is enabled
    always @(posedge clk) begin
        #2;
        if (bus.ack != 0) chk("ack_implies_gate", {31'b0, bus.gate_en}, 32'd1);
    end

    initial begin
        bus.req = '0;
        bus.force_on = 1'b0;
        #3;
        chk("rst_ack", bus.ack, 0);
        chk("rst_gate", bus.gate_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wcnt", bus.wake_cnt, 0);
        #9 rst_n = 1'b1;
        tick(1);
        chk("off_busy", bus.busy, 0);
        // wake-up: E0 samples demand
        bus.req = 4'b0001;
        tick(1);
        chk("e0_busy", bus.busy, 1);
        chk("e0_wcnt", bus.wake_cnt, 1);
        chk("e0_gate_pre_neg", bus.gate_en, 0);
        at_neg;
        chk("e0_gate_neg", bus.gate_en, 1);
        tick(1);
        chk("e1_ack", bus.ack, 0);
        tick(1);
        chk("e2_ack", bus.ack, 4'b0001);
        // req bit rising in ON
        bus.req = 4'b0011;
        tick(1);
        chk("on_rise_ack", bus.ack, 4'b0011);
        // shutdown with IDLE_CYC=16
        bus.req = 4'b0000;
        tick(1);
        chk("ek_ack", bus.ack, 0);
        chk("ek_busy", bus.busy, 1);
        tick(15);
        chk("k15_busy", bus.busy, 1);
        chk("k15_gate", bus.gate_en, 1);
        tick(1);
        chk("k16_busy", bus.busy, 0);
        chk("k16_gate_pre_neg", bus.gate_en, 1);
        at_neg;
        chk("k16_gate_neg", bus.gate_en, 0);
        // wake again, then re-request during IDLE
        tick(1);
        bus.req = 4'b0001;
        tick(3);
        chk("wake2_ack", bus.ack, 4'b0001);
        chk("wake2_wcnt", bus.wake_cnt, 2);
        bus.req = 4'b0000;
        tick(5);
        bus.req = 4'b0100;
        tick(1);
        chk("idle_regrant_ack", bus.ack, 4'b0100);
        chk("idle_regrant_wcnt", bus.wake_cnt, 2);
        // demand arriving on the IDLE cnt==0 edge
        bus.req = 4'b0000;
        tick(16);
        chk("cnt0_busy", bus.busy, 1);
        bus.req = 4'b0010;
        tick(1);
        chk("cnt0_ack", bus.ack, 4'b0010);
        chk("cnt0_busy2", bus.busy, 1);
        at_neg;
        chk("cnt0_gate", bus.gate_en, 1);
        chk("cnt0_wcnt", bus.wake_cnt, 2);
        // force_on alone holds ON with no grants
        tick(1);
        bus.force_on = 1'b1;
        bus.req = 4'b0000;
        tick(20);
        chk("force_ack", bus.ack, 0);
        chk("force_gate", bus.gate_en, 1);
        chk("force_busy", bus.busy, 1);
        bus.force_on = 1'b0;
        tick(16);
        chk("unforce_busy15", bus.busy, 1);
        tick(1);
        chk("unforce_off", bus.busy, 0);
        at_neg;
        chk("unforce_gate", bus.gate_en, 0);
        // reset in ON with all requesters active
        tick(1);
        bus.req = 4'b1111;
        tick(1);
        chk("wake3_wcnt", bus.wake_cnt, 3);
        tick(2);
        chk("all_ack", bus.ack, 4'b1111);
        rst_n = 1'b0;
        #1;
        chk("mrst_ack", bus.ack, 0);
        chk("mrst_gate", bus.gate_en, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_wcnt", bus.wake_cnt, 0);
        #1 rst_n = 1'b1;
        tick(1);
        chk("post_rst_busy", bus.busy, 1);
        chk("post_rst_wcnt", bus.wake_cnt, 1);
        tick(2);
        chk("post_rst_ack", bus.ack, 4'b1111);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
